// File: rtl/fifo_stream_reader.sv
// Purpose: read-side master for the synchronous FIFO, re-presenting its words as a valid/ready stream.
// Latency: two cycles from read enable to m_valid_o; sustains one word per cycle with m_ready_i high.
// Backpressure: reads are credit-limited by buffer space, so a stalled consumer never loses or overflows a word.
// Optional delivered-word counter enabled by defining FIFO_STREAM_READER_CNT_EN.
module fifo_stream_reader #(
    parameter int WIDTH     = 8,
    parameter int BUF_DEPTH = 2,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 enable_i,
    input  logic [WIDTH-1:0]     fifo_rdata_i,
    input  logic                 fifo_empty_i,
    input  logic                 fifo_rd_error_i,
    output logic                 fifo_rd_en_o,
    output logic [WIDTH-1:0]     m_data_o,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic                 busy_o,
    output logic                 err_o,
    output logic [CNT_WIDTH-1:0] rd_count_o
);

    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] buf_mem [BUF_DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;
    logic             inflight;

    logic             pop;
    logic             capture;
    logic [CW:0]      credit;

    // A word returning with the underflow flag set is dropped rather than buffered.
    assign pop      = m_valid_o & m_ready_i;
    assign capture  = inflight & ~fifo_rd_error_i;

    // Occupancy after this cycle if we issue nothing: the pop credit lets a read
    // go out in the same cycle a word leaves, giving full throughput.
    assign credit   = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);

    assign fifo_rd_en_o = (state == RUN) & ~fifo_empty_i & (credit < (CW+1)'(BUF_DEPTH));

    assign m_valid_o = (count != '0);
    assign m_data_o  = buf_mem[head];

    // Control FSM: fetch in RUN, finish outstanding words in DRAIN, park in IDLE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= IDLE;
            busy_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable_i) begin
                        state  <= RUN;
                        busy_o <= 1'b1;
                    end
                end
                RUN: begin
                    if (!enable_i) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (enable_i) begin
                        state <= RUN;
                    end else if ((count == '0) && !inflight && !capture) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

    // Circular output buffer plus the one-bit tracker for the FIFO's read latency.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_mem[i] <= '0;
            end
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rd_en_o;
            if (capture) begin
                buf_mem[tail] <= fifo_rdata_i;
                tail          <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            count <= count + CW'(capture) - CW'(pop);
        end
    end

    // Sticky protocol error: any underflow report latches until reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_o <= 1'b0;
        end else if (fifo_rd_error_i) begin
            err_o <= 1'b1;
        end
    end

`ifdef FIFO_STREAM_READER_CNT_EN
    logic [CNT_WIDTH-1:0] rd_count;

    // Count every word handed to the consumer, wrapping at the counter width.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_count <= '0;
        end else if (pop) begin
            rd_count <= rd_count + 1'b1;
        end
    end

    assign rd_count_o = rd_count;
`else
    assign rd_count_o = '0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader against a small behavioural FIFO model.
// Inputs change 1 time unit after the rising edge; outputs are observed on the falling edge.
// Expected values are hand-derived constants and the bench's own FIFO/scoreboard.
module tb_fifo_stream_reader;

    localparam int WIDTH     = 8;
    localparam int BUF_DEPTH = 2;
    localparam int CNT_WIDTH = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 enable;
    logic [WIDTH-1:0]     fifo_rdata;
    logic                 fifo_empty;
    logic                 fifo_rd_error;
    logic                 fifo_rd_en;
    logic [WIDTH-1:0]     m_data;
    logic                 m_valid;
    logic                 m_ready;
    logic                 busy;
    logic                 err;
    logic [CNT_WIDTH-1:0] rd_count;

    always #5 clk = ~clk;

    fifo_stream_reader #(
        .WIDTH     (WIDTH),
        .BUF_DEPTH (BUF_DEPTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .enable_i        (enable),
        .fifo_rdata_i    (fifo_rdata),
        .fifo_empty_i    (fifo_empty),
        .fifo_rd_error_i (fifo_rd_error),
        .fifo_rd_en_o    (fifo_rd_en),
        .m_data_o        (m_data),
        .m_valid_o       (m_valid),
        .m_ready_i       (m_ready),
        .busy_o          (busy),
        .err_o           (err),
        .rd_count_o      (rd_count)
    );

    // Behavioural FIFO: one-cycle registered read, combinational empty.
    logic [7:0] fmem [256];
    int         wp = 0;
    int         rp = 0;
    logic       flush = 1'b0;

    assign fifo_empty = (wp == rp);

    always @(posedge clk) begin
        if (flush) begin
            rp <= wp;
        end else if (fifo_rd_en && (wp != rp)) begin
            fifo_rdata <= fmem[rp[7:0]];
            rp         <= rp + 1;
        end
    end

    // Monitor on the falling edge.
    logic [7:0] got [$];
    int         pop_cyc [$];
    int         rd_cyc [$];
    int         bad_rd = 0;
    int         cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            got.push_back(m_data);
            pop_cyc.push_back(cyc);
        end
        if (fifo_rd_en) rd_cyc.push_back(cyc);
        if (fifo_rd_en && fifo_empty) bad_rd++;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] d);
        fmem[wp[7:0]] = d;
        wp = wp + 1;
    endtask

    task automatic clr();
        got.delete();
        pop_cyc.delete();
        rd_cyc.delete();
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_cnt;

        rst_n         = 1'b0;
        enable        = 1'b0;
        m_ready       = 1'b0;
        fifo_rd_error = 1'b0;
        #3;
        chk("reset_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("reset_valid", 32'(m_valid), 32'd0);
        chk("reset_data", 32'(m_data), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_count", 32'(rd_count), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick();

        // Three words at full rate.
        clr();
        push(8'h11); push(8'h22); push(8'h33);
        enable  = 1'b1;
        m_ready = 1'b1;
        tick(8);
        chk("t1_reads", 32'(rd_cyc.size()), 32'd3);
        if (rd_cyc.size() == 3) chk("t1_rd_span", 32'(rd_cyc[2] - rd_cyc[0]), 32'd2);
        chk("t1_words", 32'(got.size()), 32'd3);
        if (got.size() == 3) begin
            chk("t1_w0", 32'(got[0]), 32'h11);
            chk("t1_w1", 32'(got[1]), 32'h22);
            chk("t1_w2", 32'(got[2]), 32'h33);
            chk("t1_vld_span", 32'(pop_cyc[2] - pop_cyc[0]), 32'd2);
        end
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_err", 32'(err), 32'd0);

        // Backpressure: only BUF_DEPTH reads while the consumer stalls.
        clr();
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(8'(8'h41 + i));
        tick(6);
        chk("t2_reads_stalled", 32'(rd_cyc.size()), 32'd2);
        chk("t2_rd_en_low", 32'(fifo_rd_en), 32'd0);
        chk("t2_valid", 32'(m_valid), 32'd1);
        chk("t2_data_held", 32'(m_data), 32'h41);
        m_ready = 1'b1;
        tick(12);
        chk("t2_reads", 32'(rd_cyc.size()), 32'd6);
        chk("t2_words", 32'(got.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            if (i < got.size()) chk("t2_word", 32'(got[i]), 32'h41 + 32'(i));

        // Drain with one read inflight and one word buffered.
        clr();
        for (int i = 0; i < 6; i++) push(8'(8'h51 + i));
        tick(3);
        enable = 1'b0;
        tick(8);
        chk("t3_reads", 32'(rd_cyc.size()), 32'd4);
        chk("t3_words", 32'(got.size()), 32'd4);
        if (got.size() == 4) chk("t3_last", 32'(got[3]), 32'h54);
        chk("t3_left_in_fifo", 32'(wp - rp), 32'd2);
        chk("t3_busy", 32'(busy), 32'd0);
        chk("t3_valid", 32'(m_valid), 32'd0);

        // FIFO runs empty, then refills.
        do_flush();
        clr();
        enable = 1'b1;
        push(8'h61); push(8'h62);
        tick(8);
        chk("t4_words", 32'(got.size()), 32'd2);
        chk("t4_rd_en_empty", 32'(fifo_rd_en), 32'd0);
        rd_cyc.delete();
        tick(5);
        chk("t4_no_reads_empty", 32'(rd_cyc.size()), 32'd0);
        push(8'hA0);
        tick(5);
        chk("t4_words_refill", 32'(got.size()), 32'd3);
        if (got.size() == 3) chk("t4_refill_word", 32'(got[2]), 32'hA0);
        chk("t4_rd_en_while_empty", 32'(bad_rd), 32'd0);

        // Sticky error, then asynchronous reset mid-burst.
        fifo_rd_error = 1'b1;
        tick();
        fifo_rd_error = 1'b0;
        chk("t5_err_set", 32'(err), 32'd1);
        tick(5);
        chk("t5_err_sticky", 32'(err), 32'd1);
        for (int i = 0; i < 4; i++) push(8'(8'h71 + i));
        tick(2);
        chk("t5_rd_en_pre", 32'(fifo_rd_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("t5_rst_valid", 32'(m_valid), 32'd0);
        chk("t5_rst_data", 32'(m_data), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_err", 32'(err), 32'd0);
        chk("t5_rst_count", 32'(rd_count), 32'd0);
        tick(2);
        rst_n = 1'b1;
        do_flush();

        // Counter: 18 pops with a 4-bit counter wraps to 2.
        clr();
        enable  = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 18; i++) push(8'(8'h80 + i));
        tick(30);
        chk("t6_words", 32'(got.size()), 32'd18);
        if (got.size() == 18) begin
            chk("t6_first", 32'(got[0]), 32'h80);
            chk("t6_last", 32'(got[17]), 32'h91);
        end
`ifdef FIFO_STREAM_READER_CNT_EN
        exp_cnt = 32'd2;
`else
        exp_cnt = 32'd0;
`endif
        chk("t6_rd_count", 32'(rd_count), exp_cnt);
        chk("t6_err_clear", 32'(err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
